// File: rtl/gf_mult_seq.sv
// Sequential GF(2^W) multiplier. Shift-and-add over S multiplier bits per
// clock with modular reduction folded into each multiplicand doubling.
// Valid/ready on both sides; one operation in flight at a time.
module gf_mult_seq #(
    parameter int             W    = 8,
    parameter logic [W-1:0]   POLY = W'('h1B),
    parameter int             S    = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y
);

    localparam int STEPS = W / S;
    localparam int CW    = $clog2(STEPS + 1);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    // The multiplier must be consumed in whole chunks of S bits.
    if ((S < 1) || (W % S != 0)) begin : g_bad_s
        $error("gf_mult_seq: W must be a positive multiple of S");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   p_q, p_d;
    logic [W-1:0]   y_q, y_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   a_step, b_step, p_step;

    // Multiply by x modulo the field polynomial (x^W term is implicit).
    function automatic logic [W-1:0] xtime(input logic [W-1:0] v);
        return {v[W-2:0], 1'b0} ^ (v[W-1] ? POLY : '0);
    endfunction

    // S chained sub-steps: conditional accumulate, double A, shift B.
    always_comb begin
        a_step = a_q;
        b_step = b_q;
        p_step = p_q;
        for (int i = 0; i < S; i++) begin
            if (b_step[0]) p_step = p_step ^ a_step;
            a_step = xtime(a_step);
            b_step = b_step >> 1;
        end
    end

    // Next-state and handshake outputs; operands only sampled in IDLE.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        p_d       = p_q;
        y_d       = y_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    p_d     = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_step;
                b_d   = b_step;
                p_d   = p_step;
                cnt_d = cnt_q + 1'b1;
                // Fixed-length run: no early exit when B drains to zero.
                if (cnt_q == LAST) begin
                    y_d     = p_step;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
        end
    end

    assign y = y_q;

endmodule

// File: tb/tb_gf_mult_seq.sv
// Bench for gf_mult_seq: four instances (S = 1,2,4,8) share one stimulus
// stream; per-instance monitors push expected products at accept and pop
// them at the output handshake, also tracking latency and hold behaviour.
module tb_gf_mult_seq;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       out_ready = 1'b0;
    logic       b2b = 1'b0;

    logic [3:0] in_ready_v;
    logic [3:0] out_valid_v;
    logic [7:0] y_v [4];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: carry-less polynomial product, then long division by x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (z[i]) p = p ^ (16'(x) << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011B << (i - 8));
        return p[7:0];
    endfunction

    task automatic chk(input bit ok, input string nm, input int s, input int act, input int exp);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s S=%0d: got %0h, wanted %0h (t=%0t)", nm, s, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int SS  = 1 << g;
        localparam int LAT = 8 / SS;

        gf_mult_seq #(.W(8), .POLY(8'h1B), .S(SS)) u_dut (
            .clk       (clk),
            .reset_n   (reset_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready_v[g]),
            .a         (a),
            .b         (b),
            .out_valid (out_valid_v[g]),
            .out_ready (out_ready),
            .y         (y_v[g])
        );

        logic [7:0] q [$];
        int         acc_cyc  = 0;
        int         ops      = 0;
        logic       acc_seen = 1'b0;
        logic       acc_b2b  = 1'b0;
        logic       ov_p     = 1'b0;
        logic       hs_p     = 1'b0;
        logic       wait_p   = 1'b0;
        logic       prim     = 1'b0;
        logic [7:0] y_p      = '0;

        // Monitor / scoreboard, sampled on the falling edge.
        always @(negedge clk) begin
            if (!reset_n) begin
                q.delete();
                ov_p     <= 1'b0;
                hs_p     <= 1'b0;
                wait_p   <= 1'b0;
                prim     <= 1'b0;
                acc_seen <= 1'b0;
                acc_b2b  <= 1'b0;
            end else begin
                chk(!(in_ready_v[g] && out_valid_v[g]), "ready_valid_excl", SS,
                    int'({in_ready_v[g], out_valid_v[g]}), 1);
                if (hs_p)
                    chk(in_ready_v[g] && !out_valid_v[g], "ready_after_handshake", SS,
                        int'(in_ready_v[g]), 1);
                if (wait_p)
                    chk(out_valid_v[g] && !in_ready_v[g], "done_hold", SS,
                        int'({out_valid_v[g], in_ready_v[g]}), 2);
                if (prim && !(out_valid_v[g] && !ov_p))
                    chk(y_v[g] == y_p, "y_stable", SS, int'(y_v[g]), int'(y_p));
                if (out_valid_v[g] && !ov_p) begin
                    chk(acc_seen, "valid_without_accept", SS, 0, 1);
                    if (acc_seen)
                        chk(cyc - acc_cyc == LAT, "latency", SS, cyc - acc_cyc, LAT);
                    acc_seen <= 1'b0;
                end
                if (out_valid_v[g] && out_ready) begin
                    if (q.size() == 0)
                        chk(1'b0, "no_expected", SS, int'(y_v[g]), 0);
                    else begin
                        chk(y_v[g] == q[0], "result", SS, int'(y_v[g]), int'(q[0]));
                        void'(q.pop_front());
                    end
                    ops <= ops + 1;
                end
                if (in_valid && in_ready_v[g]) begin
                    if (b2b && acc_b2b)
                        chk(cyc + 1 - acc_cyc == LAT + 2, "accept_spacing", SS,
                            cyc + 1 - acc_cyc, LAT + 2);
                    q.push_back(gmul(a, b));
                    acc_cyc  <= cyc + 1;
                    acc_b2b  <= b2b;
                    acc_seen <= 1'b1;
                end
                ov_p   <= out_valid_v[g];
                hs_p   <= out_valid_v[g] && out_ready;
                wait_p <= out_valid_v[g] && !out_ready;
                y_p    <= y_v[g];
                prim   <= 1'b1;
            end
        end
    end

    task automatic wait_all_ready();
        int n = 0;
        while (in_ready_v != 4'hF && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(in_ready_v == 4'hF, "wait_all_ready", 0, int'(in_ready_v), 15);
    endtask

    task automatic wait_all_valid();
        int n = 0;
        while (out_valid_v != 4'hF && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk(out_valid_v == 4'hF, "wait_all_valid", 0, int'(out_valid_v), 15);
    endtask

    // One operation on all instances; inputs are scrambled while results wait.
    task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input int hold);
        wait_all_ready();
        @(posedge clk); #1;
        in_valid = 1'b1; a = av; b = bv; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_all_valid();
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            in_valid = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        wait_all_ready();
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Asynchronous reset state, checked before any clock edge.
        #1 reset_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk(in_ready_v[k] == 1'b1, "reset_in_ready", 1 << k, int'(in_ready_v[k]), 1);
            chk(out_valid_v[k] == 1'b0, "reset_out_valid", 1 << k, int'(out_valid_v[k]), 0);
            chk(y_v[k] == 8'h00, "reset_y", 1 << k, int'(y_v[k]), 0);
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Directed operands, including the reduction path and identities.
        do_op(8'h57, 8'h83, 0);
        do_op(8'h57, 8'h13, 0);
        do_op(8'h80, 8'h02, 0);
        do_op(8'h00, 8'hA5, 0);
        do_op(8'h5A, 8'h00, 0);
        do_op(8'h01, 8'hC3, 0);
        do_op(8'hE7, 8'h01, 0);
        do_op(8'hFF, 8'hFF, 5);
        do_op(8'h3C, 8'h9D, 5);

        // Abort mid-run, then accept on the very first edge after release.
        wait_all_ready();
        @(posedge clk); #1;
        in_valid = 1'b1; a = 8'hC9; b = 8'h6E; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk(y_v[k] == 8'h00, "abort_y", 1 << k, int'(y_v[k]), 0);
            chk(out_valid_v[k] == 1'b0, "abort_out_valid", 1 << k, int'(out_valid_v[k]), 0);
            chk(in_ready_v[k] == 1'b1, "abort_in_ready", 1 << k, int'(in_ready_v[k]), 1);
        end
        @(posedge clk); #1;
        reset_n = 1'b1; in_valid = 1'b1; a = 8'h02; b = 8'h87;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        wait_all_ready();
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Back-to-back: in_valid and out_ready held high.
        wait_all_ready();
        @(posedge clk); #1;
        b2b = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            case (i % 3)
                0:       begin a = 8'h00;        b = 8'($urandom); end
                1:       begin a = 8'($urandom); b = 8'h00;        end
                default: begin a = 8'h01;        b = 8'hC3;        end
            endcase
            @(posedge clk); #1;
        end
        in_valid = 1'b0; b2b = 1'b0;
        wait_all_ready();

        // Random traffic with random backpressure.
        n = 0;
        while (g_dut[0].ops < 1000 && n < 40000) begin
            @(posedge clk); #1;
            in_valid  = ($urandom % 4) != 0;
            a         = 8'($urandom);
            b         = 8'($urandom);
            out_ready = ($urandom % 4) != 0;
            n++;
        end
        chk(g_dut[0].ops >= 1000, "random_ops", 1, g_dut[0].ops, 1000);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        wait_all_ready();
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
